// File: rtl/mem_bus_arbiter.sv
// Two-port arbiter (instruction fetch vs. data) in front of a single SPI memory engine.
// Data has priority; a bounded starvation counter guarantees fetch forward progress.
module mem_bus_arbiter #(
  parameter int ADDR_W       = 17,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  // fetch port
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_done,
  output logic [31:0]       if_rdata,
  // data port
  input  logic              d_req,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [2:0]        d_nbytes,
  input  logic              d_we,
  input  logic [31:0]       d_wdata,
  output logic              d_done,
  output logic [31:0]       d_rdata,
  // memory engine
  output logic              mem_start,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [2:0]        mem_nbytes,
  output logic              mem_we,
  output logic [31:0]       mem_wdata,
  input  logic              mem_done,
  input  logic [31:0]       mem_rdata,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, RELEASE} state_t;

  localparam int CW = $clog2(STARVE_LIMIT + 2);
  localparam logic [CW-1:0] LIM = CW'(STARVE_LIMIT);

  state_t            state_q;
  logic [CW-1:0]     starve_cnt_q;
  logic              gnt_fetch_q;
  logic              mem_start_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [2:0]        mem_nbytes_q;
  logic              mem_we_q;
  logic [31:0]       mem_wdata_q;
  logic              if_done_q, d_done_q;
  logic [31:0]       if_rdata_q, d_rdata_q;

  logic              fetch_win;
  logic [31:0]       rdata_fmt;

  // Engine buffer holds the first received byte in the MSB; reorder to little-endian.
  function automatic logic [31:0] fmt_rdata(input logic [2:0] nb, input logic [31:0] raw);
    case (nb)
      3'd1:    fmt_rdata = {24'b0, raw[7:0]};
      3'd2:    fmt_rdata = {16'b0, raw[7:0], raw[15:8]};
      default: fmt_rdata = {raw[7:0], raw[15:8], raw[23:16], raw[31:24]};
    endcase
  endfunction

  assign fetch_win = if_req && (!d_req || (starve_cnt_q == LIM));
  assign rdata_fmt = fmt_rdata(mem_nbytes_q, mem_rdata);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      starve_cnt_q <= '0;
      gnt_fetch_q  <= 1'b0;
      mem_start_q  <= 1'b0;
      mem_addr_q   <= '0;
      mem_nbytes_q <= '0;
      mem_we_q     <= 1'b0;
      mem_wdata_q  <= '0;
      if_done_q    <= 1'b0;
      d_done_q     <= 1'b0;
      if_rdata_q   <= '0;
      d_rdata_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (!if_req) starve_cnt_q <= '0;
          if (if_req || d_req) begin
            state_q     <= ISSUE;
            mem_start_q <= 1'b1;
            gnt_fetch_q <= fetch_win;
            if (fetch_win) begin
              mem_addr_q   <= if_addr;
              mem_nbytes_q <= 3'd4;
              mem_we_q     <= 1'b0;
              mem_wdata_q  <= '0;
              starve_cnt_q <= '0;
            end else begin
              mem_addr_q   <= d_addr;
              mem_nbytes_q <= d_nbytes;
              mem_we_q     <= d_we;
              mem_wdata_q  <= d_wdata;
              if (if_req && (starve_cnt_q != LIM)) starve_cnt_q <= starve_cnt_q + 1'b1;
            end
          end
        end
        ISSUE: begin
          // Requester inputs are ignored here; the granted fields stay on mem_*.
          if (mem_done) begin
            state_q     <= RELEASE;
            mem_start_q <= 1'b0;
            if (gnt_fetch_q) begin
              if_rdata_q <= rdata_fmt;
              if_done_q  <= 1'b1;
            end else begin
              d_rdata_q <= rdata_fmt;
              d_done_q  <= 1'b1;
            end
          end
        end
        RELEASE: begin
          if_done_q <= 1'b0;
          d_done_q  <= 1'b0;
          state_q   <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mem_start  = mem_start_q;
  assign mem_addr   = mem_addr_q;
  assign mem_nbytes = mem_nbytes_q;
  assign mem_we     = mem_we_q;
  assign mem_wdata  = mem_wdata_q;
  assign if_done    = if_done_q;
  assign if_rdata   = if_rdata_q;
  assign d_done     = d_done_q;
  assign d_rdata    = d_rdata_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: the bench plays the memory engine and both requesters.
module tb_mem_bus_arbiter;
  localparam int ADDR_W = 17;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              if_req = 1'b0;
  logic [ADDR_W-1:0] if_addr = '0;
  logic              if_done;
  logic [31:0]       if_rdata;
  logic              d_req = 1'b0;
  logic [ADDR_W-1:0] d_addr = '0;
  logic [2:0]        d_nbytes = 3'd0;
  logic              d_we = 1'b0;
  logic [31:0]       d_wdata = '0;
  logic              d_done;
  logic [31:0]       d_rdata;
  logic              mem_start;
  logic [ADDR_W-1:0] mem_addr;
  logic [2:0]        mem_nbytes;
  logic              mem_we;
  logic [31:0]       mem_wdata;
  logic              mem_done = 1'b0;
  logic [31:0]       mem_rdata = '0;
  logic              busy;

  int total = 0;
  int bad   = 0;

  mem_bus_arbiter #(.ADDR_W(ADDR_W), .STARVE_LIMIT(4)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_rdata(if_rdata),
    .d_req(d_req), .d_addr(d_addr), .d_nbytes(d_nbytes), .d_we(d_we), .d_wdata(d_wdata),
    .d_done(d_done), .d_rdata(d_rdata),
    .mem_start(mem_start), .mem_addr(mem_addr), .mem_nbytes(mem_nbytes), .mem_we(mem_we),
    .mem_wdata(mem_wdata), .mem_done(mem_done), .mem_rdata(mem_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // Wait for a grant, check the mem_* fields, answer after dly cycles, check completion.
  // Called and returns at a negedge; on return the DUT is in RELEASE.
  task automatic serve(input string tag, input logic fe, input logic [31:0] addr,
                       input logic [31:0] nb, input logic [31:0] we, input logic [31:0] wdata,
                       input logic [31:0] raw, input logic [31:0] exp_rd, input int dly);
    int n = 0;
    while (!mem_start && n < 20) begin @(negedge clk); n++; end
    chk({tag, "_start"}, 32'(mem_start), 32'd1);
    if (mem_start) begin
      chk({tag, "_addr"}, 32'(mem_addr), addr);
      chk({tag, "_nbytes"}, 32'(mem_nbytes), nb);
      chk({tag, "_we"}, 32'(mem_we), we);
      chk({tag, "_wdata"}, mem_wdata, wdata);
      chk({tag, "_busy"}, 32'(busy), 32'd1);
      repeat (dly) @(negedge clk);
      chk({tag, "_held"}, 32'(mem_start), 32'd1);
      mem_rdata = raw;
      mem_done  = 1'b1;
      @(negedge clk);
      mem_done = 1'b0;
      chk({tag, "_rel_start"}, 32'(mem_start), 32'd0);
      chk({tag, "_if_done"}, 32'(if_done), 32'(fe));
      chk({tag, "_d_done"}, 32'(d_done), 32'(!fe));
      if (fe) chk({tag, "_if_rdata"}, if_rdata, exp_rd);
      else    chk({tag, "_d_rdata"}, d_rdata, exp_rd);
    end
  endtask

  initial begin
    // reset with a pending request: nothing may be granted
    d_req = 1'b1; d_addr = 17'h00055; d_nbytes = 3'd4;
    repeat (3) @(negedge clk);
    chk("rst_start", 32'(mem_start), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_addr", 32'(mem_addr), 32'd0);
    chk("rst_rdata", if_rdata | d_rdata, 32'd0);
    chk("rst_done", 32'({if_done, d_done}), 32'd0);
    d_req = 1'b0;

    // fetch only; first grant on first edge with rst low
    rst = 1'b0; if_req = 1'b1; if_addr = 17'h00100;
    @(negedge clk);
    chk("fe_latency", 32'(mem_start), 32'd1);
    serve("fe", 1'b1, 32'h00100, 32'd4, 32'd0, 32'd0, 32'h11223344, 32'h44332211, 2);
    if_req = 1'b0;
    @(negedge clk);
    chk("fe_pulse_end", 32'(if_done), 32'd0);
    chk("fe_idle_busy", 32'(busy), 32'd0);
    @(negedge clk);
    chk("fe_no_regrant", 32'(mem_start), 32'd0);

    // collision: data first, fetch after RELEASE + IDLE
    if_req = 1'b1; if_addr = 17'h00200;
    d_req = 1'b1; d_addr = 17'h10040; d_nbytes = 3'd2; d_we = 1'b0; d_wdata = 32'h0;
    serve("col_d", 1'b0, 32'h10040, 32'd2, 32'd0, 32'd0, 32'h0000ABCD, 32'h0000CDAB, 1);
    d_req = 1'b0;
    @(negedge clk);
    chk("col_idle_gap", 32'(mem_start), 32'd0);
    @(negedge clk);
    chk("col_fe_grant", 32'(mem_start), 32'd1);
    serve("col_f", 1'b1, 32'h00200, 32'd4, 32'd0, 32'd0, 32'hA1B2C3D4, 32'hD4C3B2A1, 0);
    chk("col_d_hold", d_rdata, 32'h0000CDAB);
    if_req = 1'b0;
    @(negedge clk);

    // starvation: four data grants, then fetch, then data again
    if_req = 1'b1; if_addr = 17'h00300;
    d_req = 1'b1; d_addr = 17'h10010; d_nbytes = 3'd1;
    for (int i = 0; i < 4; i++)
      serve($sformatf("stv_d%0d", i), 1'b0, 32'h10010, 32'd1, 32'd0, 32'd0,
            32'h000000F0 + 32'(i), 32'h000000F0 + 32'(i), 0);
    serve("stv_f", 1'b1, 32'h00300, 32'd4, 32'd0, 32'd0, 32'h01020304, 32'h04030201, 0);
    if_req = 1'b0;
    serve("stv_d_resume", 1'b0, 32'h10010, 32'd1, 32'd0, 32'd0, 32'h123456EF, 32'h000000EF, 0);
    d_req = 1'b0;
    @(negedge clk);

    // byte store
    d_req = 1'b1; d_addr = 17'h10008; d_nbytes = 3'd1; d_we = 1'b1; d_wdata = 32'h000000A5;
    serve("st", 1'b0, 32'h10008, 32'd1, 32'd1, 32'h000000A5, 32'hDEADBEEF, 32'h000000EF, 1);
    d_req = 1'b0; d_we = 1'b0;
    @(negedge clk);
    chk("st_pulse_end", 32'(d_done), 32'd0);
    chk("st_idle_start", 32'(mem_start), 32'd0);

    // reset three cycles into ISSUE aborts without a done pulse
    d_req = 1'b1; d_addr = 17'h0AAAA; d_nbytes = 3'd4; d_wdata = 32'h0;
    @(negedge clk);
    chk("ra_start", 32'(mem_start), 32'd1);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("ra_start_low", 32'(mem_start), 32'd0);
    chk("ra_addr", 32'(mem_addr), 32'd0);
    chk("ra_nbytes", 32'(mem_nbytes), 32'd0);
    chk("ra_done", 32'({if_done, d_done}), 32'd0);
    chk("ra_rdata", if_rdata | d_rdata, 32'd0);
    chk("ra_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    serve("ra_after", 1'b0, 32'h0AAAA, 32'd4, 32'd0, 32'd0, 32'h55667788, 32'h88776655, 1);
    d_req = 1'b0;
    @(negedge clk);

    // inputs changed during ISSUE must not reach mem_*
    d_req = 1'b1; d_addr = 17'h01234; d_nbytes = 3'd4;
    @(negedge clk);
    d_addr = 17'h1FFFF; d_nbytes = 3'd1; d_req = 1'b0;
    @(negedge clk);
    chk("hold_addr", 32'(mem_addr), 32'h01234);
    serve("hold", 1'b0, 32'h01234, 32'd4, 32'd0, 32'd0, 32'hCAFEF00D, 32'h0DF0FECA, 1);
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
